// File: rtl/data_mem_ctrl_if.sv
// data_mem_ctrl_if: request/response bundle between the datapath (master) and the data-memory responder (slave)
interface data_mem_ctrl_if;
  logic        re_in;
  logic        we_in;
  logic [1:0]  size_in;
  logic        signed_in;
  logic [31:0] addr_in;
  logic [31:0] wr_data_in;
  logic [31:0] rd_data_out;
  logic        ready_out;
  logic        misaligned_out;
  modport master (
    output re_in, we_in, size_in, signed_in, addr_in, wr_data_in,
    input  rd_data_out, ready_out, misaligned_out
  );
  modport slave (
    input  re_in, we_in, size_in, signed_in, addr_in, wr_data_in,
    output rd_data_out, ready_out, misaligned_out
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: big-endian byte/half/word data RAM responder with ready stall; ports clk_in, rst_in (async high), bus (slave: re/we/size/signed/addr/wr_data in, rd_data/ready/misaligned out)
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input logic            clk_in,
  input logic            rst_in,
  data_mem_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0] wdata_q, rd_q, rd_d, word, sh, ext, wdat;
  logic [1:0] size_q;
  logic [3:0] wmask;
  logic [15:0] half;
  logic [7:0] byt;
  logic sgn_q, wr_q, err_q, req, legal, unused_addr;
  assign unused_addr = ^bus.addr_in[31:ADDR_WIDTH+2];
  assign req = bus.re_in | bus.we_in;
  assign legal = bus.size_in == 2'b11 ? bus.addr_in[1:0] == 2'b00 :
                 bus.size_in == 2'b01 ? !bus.addr_in[0] : bus.size_in == 2'b00;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = state_q == IDLE ? (req ? (legal ? ACCESS : DONE) : IDLE) :
              state_q == ACCESS ? DONE : IDLE;
  always_comb begin
    bus.ready_out = !rst_in && ((state_q == IDLE && !req) || state_q == DONE);
    bus.misaligned_out = state_q == DONE && err_q;
    bus.rd_data_out = rd_q;
  end
  assign word = mem[addr_q[ADDR_WIDTH+1:2]];
  // big-endian: byte offset 0 lives in bits [31:24], so shift right by (3-offset)*8
  assign sh = word >> {~addr_q[1:0], 3'b000};
  assign byt = sh[7:0];
  assign half = addr_q[1] ? word[15:0] : word[31:16];
  assign ext = size_q == 2'b11 ? word :
               size_q == 2'b01 ? {{16{sgn_q & half[15]}}, half} :
               {{24{sgn_q & byt[7]}}, byt};
  assign wmask = size_q == 2'b11 ? 4'b1111 :
                 size_q == 2'b01 ? (addr_q[1] ? 4'b0011 : 4'b1100) :
                 4'b1000 >> addr_q[1:0];
  assign wdat = size_q == 2'b11 ? wdata_q :
                size_q == 2'b01 ? {2{wdata_q[15:0]}} : {4{wdata_q[7:0]}};
  assign rd_d = (state_q == ACCESS && !wr_q) ? ext : rd_q;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      addr_q <= '0;
      size_q <= '0;
      sgn_q <= 1'b0;
      wdata_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= '0;
    end else begin
      if (state_q == IDLE && req) begin
        addr_q <= bus.addr_in[ADDR_WIDTH+1:0];
        size_q <= bus.size_in;
        sgn_q <= bus.signed_in;
        wdata_q <= bus.wr_data_in;
        wr_q <= bus.we_in;
        err_q <= !legal;
      end
      rd_q <= rd_d;
    end
  // erroring requests never reach ACCESS, so they can never write
  always_ff @(posedge clk_in)
    if (!rst_in && state_q == ACCESS && wr_q)
      for (int i = 0; i < 4; i++)
        if (wmask[i]) mem[addr_q[ADDR_WIDTH+1:2]][8*i +: 8] <= wdat[8*i +: 8];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
module tb_data_mem_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [31:0] done_rd;
  data_mem_ctrl_if bus();
  data_mem_ctrl #(.ADDR_WIDTH(8)) dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic op(input string tag, input logic r, input logic w, input logic [1:0] s,
                    input logic sg, input logic [31:0] a, input logic [31:0] d, input logic err);
    bus.re_in = r;
    bus.we_in = w;
    bus.size_in = s;
    bus.signed_in = sg;
    bus.addr_in = a;
    bus.wr_data_in = d;
    #1;
    chk({tag, " req_ready"}, bus.ready_out, 0);
    @(negedge clk);
    if (!err) begin
      chk({tag, " acc_ready"}, bus.ready_out, 0);
      chk({tag, " acc_mis"}, bus.misaligned_out, 0);
      @(negedge clk);
    end
    chk({tag, " done_ready"}, bus.ready_out, 1);
    chk({tag, " done_mis"}, bus.misaligned_out, {31'b0, err});
    done_rd = bus.rd_data_out;
    bus.re_in = 1'b0;
    bus.we_in = 1'b0;
    @(negedge clk);
    chk({tag, " idle_ready"}, bus.ready_out, 1);
    chk({tag, " idle_mis"}, bus.misaligned_out, 0);
  endtask
  initial begin
    bus.re_in = 1'b0;
    bus.we_in = 1'b0;
    bus.size_in = 2'b00;
    bus.signed_in = 1'b0;
    bus.addr_in = '0;
    bus.wr_data_in = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", bus.ready_out, 0);
    chk("rst_rd", bus.rd_data_out, 0);
    chk("rst_mis", bus.misaligned_out, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", bus.ready_out, 1);
    @(negedge clk);
    op("sw10", 0, 1, 2'b11, 0, 32'h10, 32'hDEADBEEF, 0);
    op("lw10", 1, 0, 2'b11, 0, 32'h10, 0, 0);
    chk("lw10_data", done_rd, 32'hDEADBEEF);
    op("sw20", 0, 1, 2'b11, 0, 32'h20, 32'h80FF7F01, 0);
    op("lb20", 1, 0, 2'b00, 1, 32'h20, 0, 0);
    chk("lb20_data", done_rd, 32'hFFFFFF80);
    op("lbu21", 1, 0, 2'b00, 0, 32'h21, 0, 0);
    chk("lbu21_data", done_rd, 32'h000000FF);
    op("lb22", 1, 0, 2'b00, 1, 32'h22, 0, 0);
    chk("lb22_data", done_rd, 32'h0000007F);
    op("lb23", 1, 0, 2'b00, 1, 32'h23, 0, 0);
    chk("lb23_data", done_rd, 32'h00000001);
    op("lhu22", 1, 0, 2'b01, 0, 32'h22, 0, 0);
    chk("lhu22_data", done_rd, 32'h00007F01);
    op("swA", 0, 1, 2'b11, 0, 32'h20, 32'hAAAAAAAA, 0);
    op("sh22", 0, 1, 2'b01, 0, 32'h22, 32'h12345678, 0);
    op("lw20a", 1, 0, 2'b11, 0, 32'h20, 0, 0);
    chk("sh22_word", done_rd, 32'hAAAA5678);
    op("lh20", 1, 0, 2'b01, 1, 32'h20, 0, 0);
    chk("lh20_data", done_rd, 32'hFFFFAAAA);
    op("sb21", 0, 1, 2'b00, 0, 32'h21, 32'h000000C3, 0);
    op("lw20b", 1, 0, 2'b11, 0, 32'h20, 0, 0);
    chk("sb21_word", done_rd, 32'hAAC35678);
    op("sw30", 0, 1, 2'b11, 0, 32'h30, 32'h11112222, 0);
    op("sw31_err", 0, 1, 2'b11, 0, 32'h31, 32'hFFFFFFFF, 1);
    op("lw30a", 1, 0, 2'b11, 0, 32'h30, 0, 0);
    chk("sw31_nowrite", done_rd, 32'h11112222);
    op("lh33_err", 1, 0, 2'b01, 1, 32'h33, 0, 1);
    chk("lh33_rd_hold", bus.rd_data_out, 32'h11112222);
    op("sz10_ld_err", 1, 0, 2'b10, 0, 32'h30, 0, 1);
    chk("sz10_rd_hold", bus.rd_data_out, 32'h11112222);
    op("sz10_st_err", 0, 1, 2'b10, 0, 32'h30, 32'h0BADF00D, 1);
    op("lw30b", 1, 0, 2'b11, 0, 32'h30, 0, 0);
    chk("sz10_nowrite", done_rd, 32'h11112222);
    op("sw400", 0, 1, 2'b11, 0, 32'h400, 32'hCAFEF00D, 0);
    op("lw000", 1, 0, 2'b11, 0, 32'h000, 0, 0);
    chk("alias_data", done_rd, 32'hCAFEF00D);
    op("rw04", 1, 1, 2'b11, 0, 32'h04, 32'h5A5A5A5A, 0);
    chk("rw04_rd_hold", bus.rd_data_out, 32'hCAFEF00D);
    op("lw04", 1, 0, 2'b11, 0, 32'h04, 0, 0);
    chk("rw04_written", done_rd, 32'h5A5A5A5A);
    op("sw40", 0, 1, 2'b11, 0, 32'h40, 32'h01234567, 0);
    bus.we_in = 1'b1;
    bus.size_in = 2'b11;
    bus.addr_in = 32'h40;
    bus.wr_data_in = 32'hFFFF0000;
    @(negedge clk);
    chk("abort_acc_ready", bus.ready_out, 0);
    rst = 1'b1;
    #1;
    chk("abort_rst_ready", bus.ready_out, 0);
    chk("abort_rst_rd", bus.rd_data_out, 0);
    @(negedge clk);
    chk("abort_hold_ready", bus.ready_out, 0);
    bus.we_in = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort_idle_ready", bus.ready_out, 1);
    @(negedge clk);
    op("lw40", 1, 0, 2'b11, 0, 32'h40, 0, 0);
    chk("abort_nowrite", done_rd, 32'h01234567);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
